// File: rtl/turn_ctrl.sv
// turn_ctrl: Gobang move sequencer. Grants stone placement to the human or
// AI front end, enforces alternating colours, keeps a circular move-history
// stack and emits single-cycle write/retract/clr pulses to the board and the
// round counter.
// Optional feature macro: TURN_CTRL_DOUBLE_RETRACT_EN -- in AI mode a single
// retract edge pops two moves (white then black) so the human moves next.
//
// Handshake: human_req/ai_req are levels held (with stable coordinates) until
// the matching one-cycle ack or rej pulse; the block then waits in REL until
// the granted request drops. retract_req acts on its rising edge only;
// clr_req acts on its rising edge and is ignored while it stays high.
module turn_ctrl #(
    parameter int HIST_DEPTH = 16,
    parameter int COORD_W    = 4
) (
    input  logic                        clk,
    input  logic                        rst_p,
    input  logic                        human_req,
    input  logic [COORD_W-1:0]          human_x,
    input  logic [COORD_W-1:0]          human_y,
    input  logic                        ai_req,
    input  logic [COORD_W-1:0]          ai_x,
    input  logic [COORD_W-1:0]          ai_y,
    input  logic                        ai_mode,
    input  logic                        retract_req,
    input  logic                        clr_req,
    input  logic                        game_over,
    input  logic                        cell_occupied,
    output logic                        write,
    output logic                        write_color,
    output logic                        retract,
    output logic                        clr,
    output logic [COORD_W-1:0]          wr_x,
    output logic [COORD_W-1:0]          wr_y,
    output logic                        human_ack,
    output logic                        ai_ack,
    output logic                        human_rej,
    output logic                        ai_rej,
    output logic                        cur_color,
    output logic                        busy,
    output logic [$clog2(HIST_DEPTH):0] hist_cnt,
    output logic [2:0]                  state_dbg
);

    localparam int PW = $clog2(HIST_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 2 * COORD_W + 1;

    // GAP is the mandatory low cycle between two retract pulses of a double pop.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOOK = 3'd1,
        S_CHK  = 3'd2,
        S_DO   = 3'd3,
        S_REL  = 3'd4,
        S_POP  = 3'd5,
        S_GAP  = 3'd6,
        S_CLR  = 3'd7
    } state_t;

    state_t state_q, state_d;

    logic               retract_q;
    logic               clr_hold_q;
    logic               occ_q;
    logic               gnt_ai_q;
    logic               abort_req_q;
    logic               pop2_q;
    logic [PW-1:0]      wp_q;
    logic [EW-1:0]      hist_mem [HIST_DEPTH];

    logic [PW-1:0]      top_idx;
    logic [COORD_W-1:0] top_x, top_y;
    logic               top_c;
    logic               retract_edge, clr_new;
    logic               human_elig, ai_elig;
    logic               place_ok, granted_req, pop2_grant;
    logic               grant_place, grant_pop, enter_clr;

    assign top_idx                 = wp_q - PW'(1);
    assign {top_x, top_y, top_c}   = hist_mem[top_idx];

    assign retract_edge = retract_req & ~retract_q;
    assign clr_new      = clr_req & ~clr_hold_q;
    assign human_elig   = human_req & (~ai_mode | ~cur_color);
    assign ai_elig      = ai_mode & ai_req & cur_color;
    assign place_ok     = ~occ_q & ~game_over;
    assign granted_req  = gnt_ai_q ? ai_req : human_req;

`ifdef TURN_CTRL_DOUBLE_RETRACT_EN
    assign pop2_grant = ai_mode & (hist_cnt >= CW'(2));
`else
    assign pop2_grant = 1'b0;
`endif

    assign grant_place = (state_q == S_IDLE) && (state_d == S_LOOK);
    assign grant_pop   = (state_q == S_IDLE) && (state_d == S_POP);
    assign enter_clr   = (state_d == S_CLR) && (state_q != S_CLR);

    assign busy      = (state_q != S_IDLE);
    assign state_dbg = state_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst_p) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and pulse outputs; a fresh clear aborts whatever is running.
    always_comb begin
        state_d   = state_q;
        write     = 1'b0;
        retract   = 1'b0;
        clr       = 1'b0;
        human_ack = 1'b0;
        ai_ack    = 1'b0;
        human_rej = 1'b0;
        ai_rej    = 1'b0;
        if (clr_new && state_q != S_CLR) begin
            state_d = S_CLR;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (clr_req) begin
                        state_d = S_IDLE;
                    end else if (retract_edge) begin
                        if (hist_cnt != '0) state_d = S_POP;
                    end else if (human_elig || ai_elig) begin
                        state_d = S_LOOK;
                    end
                end
                S_LOOK: state_d = S_CHK;
                S_CHK:  state_d = S_DO;
                S_DO: begin
                    write     = place_ok;
                    human_ack = place_ok & ~gnt_ai_q;
                    ai_ack    = place_ok & gnt_ai_q;
                    human_rej = ~place_ok & ~gnt_ai_q;
                    ai_rej    = ~place_ok & gnt_ai_q;
                    state_d   = S_REL;
                end
                S_REL: if (!granted_req) state_d = S_IDLE;
                S_POP: begin
                    retract = 1'b1;
                    state_d = pop2_q ? S_GAP : S_IDLE;
                end
                S_GAP:  state_d = S_POP;
                S_CLR: begin
                    clr     = 1'b1;
                    state_d = abort_req_q ? S_REL : S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Turn, history pointer/count and output address/colour registers.
    always_ff @(posedge clk) begin
        if (rst_p) begin
            retract_q   <= 1'b0;
            clr_hold_q  <= 1'b0;
            occ_q       <= 1'b0;
            gnt_ai_q    <= 1'b0;
            abort_req_q <= 1'b0;
            pop2_q      <= 1'b0;
            wp_q        <= '0;
            hist_cnt    <= '0;
            cur_color   <= 1'b0;
            wr_x        <= '0;
            wr_y        <= '0;
            write_color <= 1'b0;
        end else begin
            retract_q  <= retract_req;
            clr_hold_q <= clr_req;
            if (state_q == S_CHK) occ_q <= cell_occupied;
            if (grant_place) begin
                wr_x        <= human_elig ? human_x : ai_x;
                wr_y        <= human_elig ? human_y : ai_y;
                gnt_ai_q    <= ~human_elig;
                write_color <= cur_color;
            end
            if (grant_pop || (state_q == S_GAP && state_d == S_POP)) begin
                wr_x        <= top_x;
                wr_y        <= top_y;
                write_color <= top_c;
            end
            if (grant_pop) pop2_q <= pop2_grant;
            if (write) begin
                wp_q      <= wp_q + PW'(1);
                cur_color <= ~cur_color;
                if (hist_cnt != CW'(HIST_DEPTH)) hist_cnt <= hist_cnt + CW'(1);
            end
            if (retract) begin
                wp_q      <= wp_q - PW'(1);
                hist_cnt  <= hist_cnt - CW'(1);
                cur_color <= top_c;
                pop2_q    <= 1'b0;
            end
            if (enter_clr) abort_req_q <= state_q inside {S_LOOK, S_CHK, S_DO, S_REL};
            if (clr) begin
                hist_cnt  <= '0;
                cur_color <= 1'b0;
                pop2_q    <= 1'b0;
            end
        end
    end

    // History storage; oldest entry is overwritten once the buffer is full.
    always_ff @(posedge clk) begin
        if (write) hist_mem[wp_q] <= {wr_x, wr_y, cur_color};
    end

endmodule

// File: tb/tb_turn_ctrl.sv
// tb_turn_ctrl: self-checking bench for turn_ctrl. A game-level model (move
// queue, colour to move, board occupancy) predicts every output pulse and
// the idle turn/history state.
module tb_turn_ctrl;

  localparam int HD = 16;

  logic       clk = 1'b0;
  logic       rst_p = 1'b1;
  logic       human_req = 1'b0, ai_req = 1'b0, ai_mode = 1'b0;
  logic [3:0] human_x = '0, human_y = '0, ai_x = '0, ai_y = '0;
  logic       retract_req = 1'b0, clr_req = 1'b0, game_over = 1'b0, cell_occupied = 1'b0;
  logic       write, write_color, retract, clr;
  logic [3:0] wr_x, wr_y;
  logic       human_ack, ai_ack, human_rej, ai_rej, cur_color, busy;
  logic [4:0] hist_cnt;
  logic [2:0] state_dbg;

  turn_ctrl #(.HIST_DEPTH(HD), .COORD_W(4)) dut (
    .clk(clk), .rst_p(rst_p),
    .human_req(human_req), .human_x(human_x), .human_y(human_y),
    .ai_req(ai_req), .ai_x(ai_x), .ai_y(ai_y), .ai_mode(ai_mode),
    .retract_req(retract_req), .clr_req(clr_req), .game_over(game_over),
    .cell_occupied(cell_occupied),
    .write(write), .write_color(write_color), .retract(retract), .clr(clr),
    .wr_x(wr_x), .wr_y(wr_y),
    .human_ack(human_ack), .ai_ack(ai_ack), .human_rej(human_rej), .ai_rej(ai_rej),
    .cur_color(cur_color), .busy(busy), .hist_cnt(hist_cnt), .state_dbg(state_dbg)
  );

  // clock/reset block: 25 MHz
  always #20 clk = ~clk;

  // model state
  logic [8:0]  m_hist[$];          // {x, y, colour}, oldest first
  logic        m_color = 1'b0;
  bit          board[15][15];
  bit          model_valid = 1'b0;
  logic [15:0] exp_q[$];           // {write,retract,clr,hack,aack,hrej,arej, x,y,colour}
  int          n_checks = 0, n_pass = 0;
  bit          prev_write = 1'b0, prev_retract = 1'b0;
  logic [8:0]  last_wr, first_ret;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // scoreboard: every pulse cycle is matched against the next expected event
  always @(negedge clk) begin
    logic [15:0] obs;
    logic [15:0] exp_v;
    if (rst_p) begin
      prev_write   = 1'b0;
      prev_retract = 1'b0;
    end else begin
      obs = {write, retract, clr, human_ack, ai_ack, human_rej, ai_rej, 9'd0};
      if (write | retract) obs[8:0] = {wr_x, wr_y, write_color};
      if (obs[15:9] != 7'd0) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0000;
        check("pulse_vs_model", obs, exp_v);
      end
      if (write)   check("write_low_before", prev_write, 0);
      if (retract) check("retract_low_before", prev_retract, 0);
      prev_write   = write;
      prev_retract = retract;
      if (model_valid && !busy) begin
        check("cur_color", cur_color, m_color);
        check("hist_cnt", hist_cnt, m_hist.size());
      end
    end
  end

  task automatic wait_idle();
    int c = 0;
    do begin @(negedge clk); c++; end while (busy && c < 50);
    check("idle_reached", busy, 0);
  endtask

  task automatic model_place(input logic [3:0] x, input logic [3:0] y);
    m_hist.push_back({x, y, m_color});
    if (m_hist.size() > HD) void'(m_hist.pop_front());
    board[x][y] = 1'b1;
    m_color = ~m_color;
  endtask

  task automatic model_clear();
    m_hist.delete();
    m_color = 1'b0;
    for (int i = 0; i < 15; i++) for (int j = 0; j < 15; j++) board[i][j] = 1'b0;
  endtask

  // driver: one placement request from the given side
  task automatic do_place(input bit by_ai, input logic [3:0] x, input logic [3:0] y, input bit go);
    int cyc = 0;
    bit seen = 0;
    bit ok;
    model_valid = 1'b0;
    ok = !board[x][y] && !go;
    if (ok) exp_q.push_back({1'b1, 2'b00, !by_ai, by_ai, 2'b00, x, y, m_color});
    else    exp_q.push_back({3'b000, 2'b00, !by_ai, by_ai, 9'd0});
    cell_occupied = board[x][y];
    game_over = go;
    if (by_ai) begin ai_x = x; ai_y = y; ai_req = 1'b1; end
    else begin human_x = x; human_y = y; human_req = 1'b1; end
    while (!seen && cyc < 20) begin
      @(negedge clk); cyc++;
      if (by_ai ? (ai_ack | ai_rej) : (human_ack | human_rej)) begin
        seen = 1;
        last_wr = {wr_x, wr_y, write_color};
      end
    end
    check("resp_latency", cyc, 3);
    if (by_ai) ai_req = 1'b0; else human_req = 1'b0;
    wait_idle();
    cell_occupied = 1'b0;
    game_over = 1'b0;
    if (ok) model_place(x, y);
    model_valid = 1'b1;
  endtask

  task automatic do_retract();
    int n;
    logic [8:0] e;
    model_valid = 1'b0;
    n = (m_hist.size() == 0) ? 0 : 1;
`ifdef TURN_CTRL_DOUBLE_RETRACT_EN
    if (ai_mode && m_hist.size() >= 2) n = 2;
`endif
    for (int i = 0; i < n; i++) exp_q.push_back({7'b0100000, m_hist[m_hist.size() - 1 - i]});
    retract_req = 1'b1;
    @(negedge clk);
    check("retract_latency", retract, (n > 0));
    first_ret = {wr_x, wr_y, write_color};
    repeat (3) @(negedge clk);
    retract_req = 1'b0;
    wait_idle();
    for (int i = 0; i < n; i++) begin
      e = m_hist.pop_back();
      board[e[8:5]][e[4:1]] = 1'b0;
      m_color = e[0];
    end
    model_valid = 1'b1;
  endtask

  task automatic do_clear();
    model_valid = 1'b0;
    exp_q.push_back({7'b0010000, 9'd0});
    clr_req = 1'b1;
    repeat (2) @(negedge clk);
    clr_req = 1'b0;
    wait_idle();
    model_clear();
    model_valid = 1'b1;
  endtask

  task automatic do_nonowner();
    int busy_cyc = 0;
    if (!ai_mode || !m_color) begin
      ai_x = 4'($urandom_range(0, 14)); ai_y = 4'($urandom_range(0, 14)); ai_req = 1'b1;
    end else begin
      human_x = 4'($urandom_range(0, 14)); human_y = 4'($urandom_range(0, 14)); human_req = 1'b1;
    end
    repeat (8) begin @(negedge clk); if (busy) busy_cyc++; end
    check("nonowner_ignored", busy_cyc, 0);
    ai_req = 1'b0;
    human_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_clear_in_chk();
    bit by_ai;
    model_valid = 1'b0;
    by_ai = ai_mode && m_color;
    exp_q.push_back({7'b0010000, 9'd0});
    cell_occupied = 1'b0;
    if (by_ai) begin ai_x = 4'd1; ai_y = 4'd2; ai_req = 1'b1; end
    else begin human_x = 4'd1; human_y = 4'd2; human_req = 1'b1; end
    repeat (2) @(negedge clk);
    clr_req = 1'b1;
    repeat (2) @(negedge clk);
    clr_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rel_waits_for_req_drop", busy, 1);
    human_req = 1'b0;
    ai_req = 1'b0;
    wait_idle();
    model_clear();
    model_valid = 1'b1;
  endtask

  initial begin
    int busy_cyc;
    int cyc;
    bit seen;
    int r;
    logic [3:0] x, y;
    logic [8:0] pick;

    // reset values
    repeat (3) @(negedge clk);
    check("reset_pulses", {write, retract, clr, human_ack, ai_ack, human_rej, ai_rej}, 0);
    check("reset_regs", {cur_color, hist_cnt, wr_x, wr_y, write_color}, 0);
    check("reset_busy", busy, 0);
    check("reset_state", state_dbg, 0);
    rst_p = 1'b0;
    model_valid = 1'b1;
    @(negedge clk);

    // first move: human black at (7,7)
    do_place(1'b0, 4'd7, 4'd7, 1'b0);
    check("t1_write", last_wr, {4'd7, 4'd7, 1'b0});
    check("t1_color", cur_color, 1);
    check("t1_hist", hist_cnt, 1);

    // AI request waits for black, then is granted
    do_clear();
    ai_mode = 1'b1;
    ai_x = 4'd8; ai_y = 4'd8; ai_req = 1'b1;
    busy_cyc = 0;
    repeat (8) begin @(negedge clk); if (busy) busy_cyc++; end
    check("ai_waits_for_black", busy_cyc, 0);
    do_place(1'b0, 4'd7, 4'd7, 1'b0);
    model_valid = 1'b0;
    exp_q.push_back({7'b1000100, 4'd8, 4'd8, 1'b1});
    cyc = 0; seen = 0;
    while (!seen && cyc < 20) begin @(negedge clk); cyc++; if (ai_ack) seen = 1; end
    check("ai_granted_after_black", seen, 1);
    ai_req = 1'b0;
    wait_idle();
    model_place(4'd8, 4'd8);
    model_valid = 1'b1;
    do_retract();
    check("retract_top", first_ret, {4'd8, 4'd8, 1'b1});
`ifdef TURN_CTRL_DOUBLE_RETRACT_EN
    check("dbl_retract_color", cur_color, 0);
    check("dbl_retract_hist", hist_cnt, 0);
`else
    check("retract_color", cur_color, 1);
    check("retract_hist", hist_cnt, 1);
`endif

    // rejects: occupied cell, then game over
    do_clear();
    ai_mode = 1'b0;
    do_place(1'b0, 4'd3, 4'd4, 1'b0);
    do_place(1'b0, 4'd3, 4'd4, 1'b0);
    check("occ_rej_hist", hist_cnt, 1);
    check("occ_rej_color", cur_color, 1);
    do_place(1'b0, 4'd5, 4'd5, 1'b1);
    check("go_rej_hist", hist_cnt, 1);
    check("go_rej_color", cur_color, 1);

    // history wrap: 17 pushes, 16 pops, one empty retract
    do_clear();
    for (int i = 0; i < 17; i++) do_place(1'b0, 4'(i % 15), 4'(i / 15), 1'b0);
    check("full_hist", hist_cnt, 16);
    check("full_color", cur_color, 1);
    for (int i = 0; i < 16; i++) do_retract();
    check("drained_hist", hist_cnt, 0);
    do_retract();
    check("empty_retract_hist", hist_cnt, 0);

    // clear while a placement sits in CHK
    do_place(1'b0, 4'd9, 4'd9, 1'b0);
    do_clear_in_chk();
    check("abort_hist", hist_cnt, 0);
    check("abort_color", cur_color, 0);

    // randomized game traffic
    for (int k = 0; k < 160; k++) begin
      r = $urandom_range(0, 19);
      if (r <= 11) begin
        if (m_hist.size() > 0 && $urandom_range(0, 3) == 0) begin
          pick = m_hist[$urandom_range(0, m_hist.size() - 1)];
          x = pick[8:5]; y = pick[4:1];
        end else begin
          x = 4'($urandom_range(0, 14)); y = 4'($urandom_range(0, 14));
        end
        do_place(ai_mode && m_color, x, y, ($urandom_range(0, 7) == 0));
      end else if (r <= 15) begin
        do_retract();
      end else if (r == 16) begin
        do_clear();
      end else if (r <= 18) begin
        do_nonowner();
      end else begin
        ai_mode = ~ai_mode;
        @(negedge clk);
      end
    end

    // reset in the middle of a placement
    model_valid = 1'b0;
    human_x = 4'd2; human_y = 4'd2; human_req = 1'b1; ai_mode = 1'b0;
    repeat (2) @(negedge clk);
    rst_p = 1'b1;
    human_req = 1'b0;
    @(negedge clk);
    check("midop_reset_pulses", {write, retract, clr, human_ack, ai_ack, human_rej, ai_rej}, 0);
    check("midop_reset_regs", {busy, cur_color, hist_cnt}, 0);
    rst_p = 1'b0;
    model_clear();
    exp_q.delete();
    model_valid = 1'b1;
    repeat (6) @(negedge clk);

    check("all_events_seen", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
